// File: rtl/mcpu_alu_exec_seq.sv
// mcpu_alu_exec_seq: handshaked execute unit with ALU-control decode.
// Define MCPU_ALU_MUL_EN to add the iterative multiplier (funct 011000).
module mcpu_alu_exec_seq #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_ALUop,
  input  logic [5:0]       i_funct,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_ovf,
  output logic             o_illegal,
  output logic [3:0]       o_ALUctrl
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [SW:0] STEP = (SW+1)'(SHIFT_STEP);

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_NOR = 4'b1000;
  localparam logic [3:0] C_XOR = 4'b1011;
  localparam logic [3:0] C_SRL = 4'b1100;
  localparam logic [3:0] C_SRA = 4'b1101;
  localparam logic [3:0] C_SLL = 4'b1110;
  localparam logic [3:0] C_ILL = 4'b1111;

`ifdef MCPU_ALU_MUL_EN
  localparam logic [3:0] C_MUL = 4'b1001;
  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t state, next;

  logic [3:0]       ctrl, dctrl, sh_op;
  logic             dill, ill, ovf, ovf_c;
  logic [WIDTH-1:0] res, res_c, sum, diff;
  logic [WIDTH-1:0] work, sh_in, shifted;
  logic [SW:0]      rem, rem_in, amt;
  logic             last, is_shift, lt;
  logic [SW-1:0]    shamt;

  assign shamt = i_b[SW-1:0];

  always_comb begin
    dctrl = C_ADD;
    dill  = 1'b0;
    case (i_ALUop)
      3'b000: dctrl = C_ADD;
      3'b001: dctrl = C_SUB;
      3'b011: dctrl = C_AND;
      3'b100: dctrl = C_SLT;
      3'b101: dctrl = C_SLL;
      3'b110: dctrl = C_SRL;
      3'b111: dctrl = C_SRA;
      default: begin
        case (i_funct)
          6'b000000,
          6'b100000: dctrl = C_ADD;
          6'b100010: dctrl = C_SUB;
          6'b100100: dctrl = C_AND;
          6'b100101: dctrl = C_OR;
          6'b100110: dctrl = C_XOR;
          6'b100111: dctrl = C_NOR;
          6'b101010: dctrl = C_SLT;
          6'b000100: dctrl = C_SLL;
          6'b101000: dctrl = C_SRL;
          6'b101001: dctrl = C_SRA;
`ifdef MCPU_ALU_MUL_EN
          6'b011000: dctrl = C_MUL;
`endif
          default: begin
            dctrl = C_ILL;
            dill  = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign is_shift = (dctrl == C_SRL) || (dctrl == C_SRA) || (dctrl == C_SLL);

  // One shifter serves both the first step at acceptance and later steps.
  assign sh_in  = (state == IDLE) ? i_a : work;
  assign sh_op  = (state == IDLE) ? dctrl : ctrl;
  assign rem_in = (state == IDLE) ? {1'b0, shamt} : rem;
  assign amt    = (rem_in < STEP) ? rem_in : STEP;
  assign last   = (rem_in <= STEP);

  always_comb begin
    case (sh_op)
      C_SRL:   shifted = sh_in >> amt;
      C_SRA:   shifted = $signed(sh_in) >>> amt;
      default: shifted = sh_in << amt;
    endcase
  end

  assign sum  = i_a + i_b;
  assign diff = i_a - i_b;
  assign lt   = $signed(i_a) < $signed(i_b);

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    case (dctrl)
      C_AND: res_c = i_a & i_b;
      C_OR:  res_c = i_a | i_b;
      C_XOR: res_c = i_a ^ i_b;
      C_NOR: res_c = ~(i_a | i_b);
      C_SLT: res_c = {{(WIDTH-1){1'b0}}, lt};
      C_ADD: begin
        res_c = sum;
        ovf_c = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                (sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      C_SUB: begin
        res_c = diff;
        ovf_c = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                (diff[WIDTH-1] != i_a[WIDTH-1]);
      end
      C_SRL, C_SRA, C_SLL: res_c = shifted;
      default: res_c = '0;
    endcase
  end

`ifdef MCPU_ALU_MUL_EN
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [WIDTH-1:0] acc_in, mc_in, mp_in, acc_n;
  logic [SW-1:0]    cnt;

  assign acc_in = (state == IDLE) ? '0 : acc;
  assign mc_in  = (state == IDLE) ? i_a : mcand;
  assign mp_in  = (state == IDLE) ? i_b : mplier;
  assign acc_n  = mp_in[0] ? acc_in + mc_in : acc_in;
`endif

  always_comb begin
    next = state;
    case (state)
      IDLE: begin
        if (i_valid) begin
          if (is_shift)
            next = last ? DONE : SHIFT;
`ifdef MCPU_ALU_MUL_EN
          else if (dctrl == C_MUL)
            next = MUL;
`endif
          else
            next = DONE;
        end
      end
      SHIFT: if (last) next = DONE;
`ifdef MCPU_ALU_MUL_EN
      MUL: if (cnt == SW'(1)) next = DONE;
`endif
      DONE: if (i_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      res  <= '0;
      ovf  <= 1'b0;
      ill  <= 1'b0;
      ctrl <= C_ADD;
      work <= '0;
      rem  <= '0;
`ifdef MCPU_ALU_MUL_EN
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            ctrl <= dctrl;
            ill  <= dill;
            ovf  <= ovf_c;
            res  <= res_c;
            work <= shifted;
            rem  <= rem_in - amt;
`ifdef MCPU_ALU_MUL_EN
            acc    <= acc_n;
            mcand  <= mc_in << 1;
            mplier <= mp_in >> 1;
            cnt    <= SW'(WIDTH - 1);
`endif
          end
        end
        SHIFT: begin
          work <= shifted;
          rem  <= rem_in - amt;
          res  <= shifted;
        end
`ifdef MCPU_ALU_MUL_EN
        MUL: begin
          acc    <= acc_n;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - SW'(1);
          res    <= acc_n;
        end
`endif
        default: ;
      endcase
    end
  end

  assign o_ready   = (state == IDLE);
  assign o_valid   = (state == DONE);
  assign o_result  = res;
  assign o_zero    = (res == '0);
  assign o_ovf     = ovf;
  assign o_illegal = ill;
  assign o_ALUctrl = ctrl;

endmodule

// File: tb/tb_mcpu_alu_exec_seq.sv
// tb_mcpu_alu_exec_seq: directed vectors for the execute unit.
// Runs SHIFT_STEP=1 and SHIFT_STEP=4 instances side by side.
module tb_mcpu_alu_exec_seq;
  logic        clk = 1'b0;
  logic        rst_n, valid, take_rdy;
  logic [2:0]  op;
  logic [5:0]  fn;
  logic [31:0] a, b;

  logic        rdy, vld, zero, ovf, ill;
  logic [31:0] res;
  logic [3:0]  ctrl;
  logic        rdy4, vld4, zero4, ovf4, ill4;
  logic [31:0] res4;
  logic [3:0]  ctrl4;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mcpu_alu_exec_seq #(.WIDTH(32), .SHIFT_STEP(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy),
    .i_ALUop(op), .i_funct(fn), .i_a(a), .i_b(b),
    .o_valid(vld), .i_ready(take_rdy), .o_result(res), .o_zero(zero),
    .o_ovf(ovf), .o_illegal(ill), .o_ALUctrl(ctrl)
  );

  mcpu_alu_exec_seq #(.WIDTH(32), .SHIFT_STEP(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy4),
    .i_ALUop(op), .i_funct(fn), .i_a(a), .i_b(b),
    .o_valid(vld4), .i_ready(take_rdy), .o_result(res4), .o_zero(zero4),
    .o_ovf(ovf4), .o_illegal(ill4), .o_ALUctrl(ctrl4)
  );

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  fn;
    logic [31:0] a, b, res;
    logic [3:0]  ctrl;
    logic        ovf, ill;
    int          lat, lat4;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] o, input logic [5:0] f,
                              input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] r, input logic [3:0] c,
                              input logic v, input logic il,
                              input int l, input int l4);
    vec_t t;
    t.op = o; t.fn = f; t.a = x; t.b = y; t.res = r;
    t.ctrl = c; t.ovf = v; t.ill = il; t.lat = l; t.lat4 = l4;
    return t;
  endfunction

  task automatic send(input logic [2:0] o, input logic [5:0] f,
                      input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    @(negedge clk);
    op = o; fn = f; a = x; b = y; valid = 1'b1;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(rdy), 32'd1);
    @(posedge clk);
    #1;
    valid = 1'b0;
    op = 3'b010; fn = 6'b111111; a = ~x; b = ~y;
  endtask

  task automatic wait_done(output int l1, output int l4);
    int n = 0;
    l1 = 1;
    l4 = 1;
    while ((!vld || !vld4) && n < 100) begin
      if (!vld)  l1++;
      if (!vld4) l4++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic take();
    @(negedge clk);
    take_rdy = 1'b1;
    @(posedge clk);
    #1;
    take_rdy = 1'b0;
    chk("idle_ready", 32'(rdy), 32'd1);
    chk("idle_valid", 32'(vld), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int l1, l4;
    send(v.op, v.fn, v.a, v.b);
    wait_done(l1, l4);
    chk($sformatf("v%0d_res", idx), res, v.res);
    chk($sformatf("v%0d_ctrl", idx), 32'(ctrl), 32'(v.ctrl));
    chk($sformatf("v%0d_ovf", idx), 32'(ovf), 32'(v.ovf));
    chk($sformatf("v%0d_ill", idx), 32'(ill), 32'(v.ill));
    chk($sformatf("v%0d_zero", idx), 32'(zero), 32'(v.res == 32'd0));
    chk($sformatf("v%0d_lat", idx), 32'(l1), 32'(v.lat));
    chk($sformatf("v%0d_res4", idx), res4, v.res);
    chk($sformatf("v%0d_lat4", idx), 32'(l4), 32'(v.lat4));
    take();
  endtask

  initial begin
    int l1, l4;
    rst_n = 1'b0; valid = 1'b0; take_rdy = 1'b0;
    op = 3'b000; fn = 6'b000000; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(vld), 32'd0);
    chk("rst_ready", 32'(rdy), 32'd1);
    chk("rst_result", res, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_ill", 32'(ill), 32'd0);
    chk("rst_ctrl", 32'(ctrl), 32'b0010);
    @(negedge clk);
    rst_n = 1'b1;

    run_vec(mk(3'b010, 6'b100000, 32'h7FFFFFFF, 32'd1, 32'h80000000,
               4'b0010, 1'b1, 1'b0, 1, 1), 0);

    send(3'b001, 6'b000000, 32'd5, 32'd5);
    wait_done(l1, l4);
    chk("sub_lat", 32'(l1), 32'd1);
    chk("sub_res", res, 32'd0);
    chk("sub_zero", 32'(zero), 32'd1);
    chk("sub_ovf", 32'(ovf), 32'd0);
    chk("sub_ctrl", 32'(ctrl), 32'b0110);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(vld), 32'd1);
      chk("hold_ready", 32'(rdy), 32'd0);
      chk("hold_res", res, 32'd0);
      chk("hold_zero", 32'(zero), 32'd1);
    end
    take();

    vecs.push_back(mk(3'b111, 6'd0, 32'h80000000, 32'd4, 32'hF8000000,
                      4'b1101, 1'b0, 1'b0, 4, 1));
    vecs.push_back(mk(3'b111, 6'd0, 32'h80000000, 32'd0, 32'h80000000,
                      4'b1101, 1'b0, 1'b0, 1, 1));
    vecs.push_back(mk(3'b111, 6'd0, 32'h80000000, 32'd7, 32'hFF000000,
                      4'b1101, 1'b0, 1'b0, 7, 2));
    vecs.push_back(mk(3'b010, 6'b111111, 32'h12345678, 32'h1, 32'h0,
                      4'b1111, 1'b0, 1'b1, 1, 1));
    vecs.push_back(mk(3'b011, 6'd0, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000,
                      4'b0000, 1'b0, 1'b0, 1, 1));
    vecs.push_back(mk(3'b010, 6'b100101, 32'h0F, 32'hF0, 32'hFF,
                      4'b0001, 1'b0, 1'b0, 1, 1));
    vecs.push_back(mk(3'b010, 6'b100110, 32'hFF00FF00, 32'h0FF00FF0,
                      32'hF0F0F0F0, 4'b1011, 1'b0, 1'b0, 1, 1));
    vecs.push_back(mk(3'b010, 6'b100111, 32'h0, 32'h0, 32'hFFFFFFFF,
                      4'b1000, 1'b0, 1'b0, 1, 1));
    vecs.push_back(mk(3'b010, 6'b101010, 32'hFFFFFFFF, 32'd1, 32'd1,
                      4'b0111, 1'b0, 1'b0, 1, 1));
    vecs.push_back(mk(3'b100, 6'd0, 32'd5, 32'hFFFFFFFE, 32'd0,
                      4'b0111, 1'b0, 1'b0, 1, 1));
    vecs.push_back(mk(3'b010, 6'b100010, 32'h80000000, 32'd1, 32'h7FFFFFFF,
                      4'b0110, 1'b1, 1'b0, 1, 1));
    vecs.push_back(mk(3'b000, 6'd0, 32'd3, 32'd4, 32'd7,
                      4'b0010, 1'b0, 1'b0, 1, 1));
    vecs.push_back(mk(3'b010, 6'b000100, 32'd1, 32'd31, 32'h80000000,
                      4'b1110, 1'b0, 1'b0, 31, 8));
    vecs.push_back(mk(3'b110, 6'd0, 32'h80000000, 32'd4, 32'h08000000,
                      4'b1100, 1'b0, 1'b0, 4, 1));
    vecs.push_back(mk(3'b010, 6'b101000, 32'hF0000000, 32'd1, 32'h78000000,
                      4'b1100, 1'b0, 1'b0, 1, 1));
    vecs.push_back(mk(3'b010, 6'b000000, 32'd1, 32'd2, 32'd3,
                      4'b0010, 1'b0, 1'b0, 1, 1));
`ifdef MCPU_ALU_MUL_EN
    vecs.push_back(mk(3'b010, 6'b011000, 32'd6, 32'd7, 32'd42,
                      4'b1001, 1'b0, 1'b0, 32, 32));
`else
    vecs.push_back(mk(3'b010, 6'b011000, 32'd6, 32'd7, 32'd0,
                      4'b1111, 1'b0, 1'b1, 1, 1));
`endif
    foreach (vecs[i]) run_vec(vecs[i], i + 1);

    send(3'b101, 6'd0, 32'd1, 32'd20);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_valid", 32'(vld), 32'd0);
    chk("mid_ready", 32'(rdy), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rrst_valid", 32'(vld), 32'd0);
    chk("rrst_ready", 32'(rdy), 32'd1);
    chk("rrst_result", res, 32'd0);
    chk("rrst_zero", 32'(zero), 32'd1);
    chk("rrst_ctrl", 32'(ctrl), 32'b0010);
    chk("rrst_ready4", 32'(rdy4), 32'd1);
    chk("rrst_valid4", 32'(vld4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(mk(3'b101, 6'd0, 32'd1, 32'd3, 32'd8,
               4'b1110, 1'b0, 1'b0, 3, 1), 99);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/mcpu_alu_exec_seq.md
Name: mcpu_alu_exec_seq

Overview:
- Parametrised, handshaked execute unit for the multi-cycle CPU.
- Merges ALU-control decode (ALUop + funct → 4-bit control code) with a registered datapath.
- Logic ops and add/sub/slt finish in 1 cycle; shifts iterate SHIFT_STEP bits per cycle; optional multiply iterates one bit per cycle.
- Sits between the control FSM / register read stage and the ALUOut register.

Parameters:
- WIDTH, 32: operand/result width; must be ≥ 4 and a power of 2.
- SHIFT_STEP, 1: bits shifted per cycle; power of 2, 1..WIDTH.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_valid  in  1  operation request.
- o_ready  out  1  unit idle, can accept a request.
- i_ALUop  in  3  ALU operation class from the control FSM.
- i_funct  in  6  R-type funct field.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B; shift amount is i_b[$clog2(WIDTH)-1:0].
- o_valid  out  1  result available.
- i_ready  in  1  consumer takes result.
- o_result  out  WIDTH  result.
- o_zero  out  1  o_result == 0.
- o_ovf  out  1  signed overflow (ADD/SUB only, else 0).
- o_illegal  out  1  undefined funct was decoded.
- o_ALUctrl  out  4  latched control code of the current/last operation.

Behaviour:
- Control codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1000, MUL 1001, XOR 1011, SRL 1100, SRA 1101, SLL 1110.
- ALUop decode:
  - 000 ADD, 001 SUB, 011 AND, 100 SLT, 101 SLL, 110 SRL, 111 SRA.
  - 010 uses funct: 000000 ADD (NOP), 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 000100 SLL, 101000 SRL, 101001 SRA, 011000 MUL (see optional feature).
  - Any other funct: illegal.
- Reset (i_rst_n=0 at edge), from any state including mid-shift or mid-multiply:
  - FSM → IDLE.
  - o_valid=0, o_result=0, o_zero=1, o_ovf=0, o_illegal=0, o_ALUctrl=0010.
  - Partial work is discarded.
- FSM states IDLE, SHIFT, MUL, DONE. o_ready=1 only in IDLE.
- IDLE:
  - Request accepted on i_valid & o_ready.
  - Operands and control code are latched.
  - Single-cycle ops (incl. illegal) → DONE with the result registered; o_valid rises the cycle after acceptance (latency 1).
  - Shifts → SHIFT. MUL → MUL.
- SHIFT:
  - Each cycle, shift the working register by min(SHIFT_STEP, remaining) bits; SRA sign-fills, SRL/SLL zero-fill.
  - → DONE when remaining reaches 0.
  - Latency = max(1, ceil(shamt/SHIFT_STEP)) cycles from acceptance to o_valid; shamt=0 gives latency 1 with result = i_a.
- MUL:
  - Unsigned shift-add, one multiplier bit per cycle, WIDTH iterations.
  - Result is the low WIDTH bits of the product; latency WIDTH.
- DONE:
  - o_valid=1; o_result, o_zero, o_ovf, o_illegal, o_ALUctrl stable.
  - → IDLE on i_ready. No new request is accepted in that same cycle; o_ready is next high in IDLE.
- Arithmetic:
  - Add/sub are WIDTH-bit modulo.
  - o_ovf = operand signs equal (add) or different (sub), and result sign differs from i_a's sign.
  - SLT is signed, result zero-extended 0/1.
- Illegal funct: o_result=0, o_zero=1, o_illegal=1, o_ALUctrl=1111.
- i_valid while not ready is ignored; the requester must hold it. Input changes after acceptance have no effect.

Optional Feature:
- Macro MCPU_ALU_MUL_EN.
- Defined: funct 011000 with ALUop 010 decodes to MUL (1001) and uses the MUL state.
- Undefined: MUL state and multiplier logic are absent; funct 011000 is illegal.

Test Plan:
- Reset, then ALUop=010, funct=100000, a=0x7FFFFFFF, b=1 → one cycle after accept: o_valid=1, result=0x80000000, o_ovf=1, o_zero=0, o_ALUctrl=0010.
- ALUop=001, a=5, b=5 → result=0, o_zero=1, o_ovf=0; i_ready held low for 3 cycles → outputs stable, o_ready=0 throughout.
- SHIFT_STEP=1, ALUop=111, a=0x80000000, b=4 → o_valid 4 cycles after accept, result=0xF8000000. Repeat with b=0 → latency 1, result=0x80000000. Repeat with SHIFT_STEP=4, b=7 → latency 2, result=0xFF000000.
- ALUop=010, funct=111111 → o_illegal=1, result=0, o_ALUctrl=1111. Next request ALUop=011, a=0xF0F0, b=0xFF00 → result=0xF000, o_illegal=0.
- With MCPU_ALU_MUL_EN: funct=011000, a=6, b=7 → o_valid exactly 32 cycles after accept, result=42. Without the macro → o_illegal=1 after 1 cycle.
- Start SLL with b=20 (SHIFT_STEP=1), assert i_rst_n=0 at cycle 5 → next cycle o_valid=0, o_ready=1, o_result=0. A new request then completes normally.
